// File: rtl/rx_axis_stats.sv
// rx_axis_stats: 10G RX AXI-Stream frame statistics (good/bad/runt/bytes/last length) behind AXI-Lite.
// Define RX_AXIS_STATS_SATURATE_EN to make every counter saturate instead of wrapping.
module rx_axis_stats #(
    parameter int AXIL_ADDR_WIDTH  = 32,
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [63:0]                s_axis_tdata,
    input  logic [7:0]                 s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t      rd_q, wr_q;
    logic [31:0] good_q, good_d, bad_q, bad_d, runt_q, runt_d, snap_q, snap_d, rdata_q, rd_mux;
    logic [63:0] bytes_q, bytes_d;
    logic [15:0] acc_q, acc_d, last_q, last_d, flen;
    logic [3:0]  cnt;
    logic        beat, eof, ar_hs, aw_hs, clr_q, arready_q, rvalid_q, bvalid_q, unused;

    function automatic logic [31:0] inc32(input logic [31:0] v);
`ifdef RX_AXIS_STATS_SATURATE_EN
        return &v ? v : v + 32'd1;
`else
        return v + 32'd1;
`endif
    endfunction

    function automatic logic [63:0] add64(input logic [63:0] v, input logic [15:0] n);
`ifdef RX_AXIS_STATS_SATURATE_EN
        logic [64:0] s;
        s = {1'b0, v} + {49'd0, n};
        return s[64] ? '1 : s[63:0];
`else
        return v + {48'd0, n};
`endif
    endfunction

    assign s_axis_tready  = rst_n;
    assign beat           = s_axis_tvalid & s_axis_tready;
    assign eof            = beat & s_axis_tlast;
    assign cnt            = 4'($countones(s_axis_tkeep));
    assign flen           = acc_q + {12'd0, cnt};
    assign ar_hs          = s_axil_arvalid & arready_q;
    assign aw_hs          = rst_n & (wr_q == IDLE) & s_axil_awvalid & s_axil_wvalid;
    assign s_axil_awready = aw_hs;
    assign s_axil_wready  = aw_hs;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;
    assign unused = ^{s_axis_tdata, s_axil_awprot, s_axil_arprot, s_axil_wdata[31:1],
                      s_axil_wstrb[3:1], s_axil_araddr, s_axil_awaddr};

    // A pending clear overrides every update in the same cycle, including a frame end.
    always_comb begin
        acc_d   = eof ? 16'd0 : beat ? flen : acc_q;
        good_d  = (eof & ~s_axis_tuser) ? inc32(good_q) : good_q;
        bad_d   = (eof & s_axis_tuser) ? inc32(bad_q) : bad_q;
        runt_d  = (eof & ({16'd0, flen} < 32'(MIN_FRAME_LENGTH))) ? inc32(runt_q) : runt_q;
        last_d  = eof ? flen : last_q;
        bytes_d = (eof & ~s_axis_tuser) ? add64(bytes_q, flen) : bytes_q;
        snap_d  = (ar_hs & (s_axil_araddr[4:2] == 3'd2)) ? bytes_q[63:32] : snap_q;
        if (clr_q) begin
            {acc_d, good_d, bad_d, runt_d, last_d, bytes_d, snap_d} = '0;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (s_axil_araddr[4:2])
            3'd0: rd_mux = good_q;
            3'd1: rd_mux = bad_q;
            3'd2: rd_mux = bytes_q[31:0];
            3'd3: rd_mux = snap_q;
            3'd4: rd_mux = runt_q;
            3'd5: rd_mux = {16'd0, last_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {acc_q, good_q, bad_q, runt_q, last_q, bytes_q, snap_q} <= '0;
        end else begin
            {acc_q, good_q, bad_q, runt_q, last_q, bytes_q, snap_q} <=
                {acc_d, good_d, bad_d, runt_d, last_d, bytes_d, snap_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else if (rd_q == IDLE) begin
            arready_q <= 1'b1;
            if (ar_hs) begin
                rdata_q   <= rd_mux;
                rvalid_q  <= 1'b1;
                arready_q <= 1'b0;
                rd_q      <= RESP;
            end
        end else if (s_axil_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_q      <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= IDLE;
            bvalid_q <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            clr_q <= aw_hs & (s_axil_awaddr[4:2] == 3'd6) & s_axil_wdata[0] & s_axil_wstrb[0];
            if (wr_q == IDLE) begin
                if (aw_hs) begin
                    bvalid_q <= 1'b1;
                    wr_q     <= RESP;
                end
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
                wr_q     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rx_axis_stats.sv
// tb_rx_axis_stats: directed scenario bench for rx_axis_stats.
module tb_rx_axis_stats;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b1;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b1;
    logic [1:0]  bresp, rresp;
    int          pass_cnt = 0, total_cnt = 0;
    logic [31:0] rd;
    logic [31:0] exp [7];

    always #5 clk = ~clk;

    rx_axis_stats dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'd0), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(3'd0), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready)
    );

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
        int t = 0;
        d = 'x;
        @(negedge clk);
        araddr = a;
        arvalid = 1'b1;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        if (t >= 50) begin
            total_cnt++;
            $display("FAIL rd_timeout addr=%h arready never seen", a);
            return;
        end
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            total_cnt++;
            $display("FAIL rvalid_timeout addr=%h", a);
        end else d = rdata;
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && t < 50) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            total_cnt++;
            $display("FAIL wr_timeout addr=%h", a);
        end
    endtask

    // Beats are presented on falling edges; tready is expected high throughout.
    task automatic send_frame(input int len, input logic bad, input logic clr_last);
        int rem = len, n;
        while (rem > 0) begin
            @(negedge clk);
            n = rem > 8 ? 8 : rem;
            tvalid = 1'b1;
            tdata = {$urandom, $urandom};
            tkeep = 8'hFF >> (8 - n);
            tlast = rem <= 8;
            tuser = bad & (rem <= 8);
            if (clr_last && rem <= 8) begin
                awaddr = 32'h18; wdata = 32'h1; wstrb = 4'hF;
                awvalid = 1'b1; wvalid = 1'b1;
                #1;
                total_cnt++;
                if (awready !== 1'b1 || wready !== 1'b1) $display("FAIL clr_on_last_accept aw=%b w=%b want 1", awready, wready);
                else pass_cnt++;
            end
            rem -= n;
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic test_reset;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({tready, arready, awready, wready, rvalid, bvalid} !== 6'b0 || rdata !== 32'd0)
            $display("FAIL reset_outputs rdy/valid=%b rdata=%h want 0", {tready, arready, awready, wready, rvalid, bvalid}, rdata);
        else pass_cnt++;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (tready !== 1'b1) $display("FAIL tready_after_reset got=%b want 1", tready);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== 32'd0) $display("FAIL reset_reg%0d got=%h want 0", i, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_good_frame;
        send_frame(64, 1'b0, 1'b0);
        exp = '{32'd1, 32'd0, 32'd64, 32'd0, 32'd0, 32'd64, 32'd0};
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL good_reg%0d got=%h want %h", i, rd, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_bad_runt;
        send_frame(60, 1'b1, 1'b0);
        exp = '{32'd1, 32'd1, 32'd64, 32'd0, 32'd1, 32'd60, 32'd0};
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL bad_runt_reg%0d got=%h want %h", i, rd, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ctrl_writes;
        axil_write(32'h18, 32'h1, 4'h0);
        axil_write(32'h00, 32'hFFFF_FFFF, 4'hF);
        axil_write(32'h18, 32'h2, 4'hF);
        axil_read(32'h00, rd);
        total_cnt++;
        if (rd !== 32'd1) $display("FAIL ignored_writes good got=%h want 1", rd);
        else pass_cnt++;
        axil_read(32'h10, rd);
        total_cnt++;
        if (rd !== 32'd1) $display("FAIL ignored_writes runts got=%h want 1", rd);
        else pass_cnt++;
        axil_write(32'h18, 32'h1, 4'h1);
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== 32'd0) $display("FAIL clear_reg%0d got=%h want 0", i, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_on_last;
        send_frame(64, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== 32'd0) $display("FAIL clr_last_reg%0d got=%h want 0", i, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous;
        send_frame(64, 1'b0, 1'b0);
        @(negedge clk);
        araddr = 32'h00; arvalid = 1'b1;
        awaddr = 32'h18; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        total_cnt++;
        if ({arready, awready, wready} !== 3'b111) $display("FAIL simul_accept got=%b want 111", {arready, awready, wready});
        else pass_cnt++;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        total_cnt++;
        if (rvalid !== 1'b1 || rdata !== 32'd1) $display("FAIL simul_read rvalid=%b rdata=%h want 1/1", rvalid, rdata);
        else pass_cnt++;
        axil_read(32'h00, rd);
        total_cnt++;
        if (rd !== 32'd0) $display("FAIL simul_after good got=%h want 0", rd);
        else pass_cnt++;
    endtask

    task automatic test_wide_bytes;
        @(negedge clk);
        force dut.bytes_q = 64'h1_FFFF_FFF8;
        @(posedge clk);
        @(negedge clk);
        release dut.bytes_q;
        send_frame(9000, 1'b0, 1'b0);
        exp = '{32'd1, 32'd0, 32'h0000_2320, 32'd2, 32'd0, 32'd9000, 32'd0};
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL wide_reg%0d got=%h want %h", i, rd, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_counter_limit;
        @(negedge clk);
        force dut.good_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.good_q;
        send_frame(64, 1'b0, 1'b0);
        axil_read(32'h00, rd);
        total_cnt++;
`ifdef RX_AXIS_STATS_SATURATE_EN
        if (rd !== 32'hFFFF_FFFF) $display("FAIL saturate good got=%h want ffffffff", rd);
`else
        if (rd !== 32'h0) $display("FAIL wrap good got=%h want 0", rd);
`endif
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            tvalid = 1'b1; tkeep = 8'hFF; tlast = 1'b0; tuser = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0; tvalid = 1'b0; tkeep = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(64, 1'b0, 1'b0);
        exp = '{32'd1, 32'd0, 32'd64, 32'd0, 32'd0, 32'd64, 32'd0};
        for (int i = 0; i < 7; i++) begin
            axil_read(32'(i * 4), rd);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL midframe_reg%0d got=%h want %h", i, rd, exp[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_runt;
        test_ctrl_writes;
        test_clear_on_last;
        test_simultaneous;
        test_wide_bytes;
        test_counter_limit;
        test_reset_midframe;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rx_axis_stats.md
RX_AXIS_STATS -- requirements
Module: rx_axis_stats

Interface
REQ-001 The block SHALL have parameter AXIL_ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 The block SHALL have parameter MIN_FRAME_LENGTH, default 64, runt threshold in bytes.
REQ-003 The block SHALL have the following port: clk, input, 1, single clock for all logic (156.25 MHz).
REQ-004 The block SHALL have the following port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have the following AXI-Stream sink ports from the 10G MAC RX FIFO:
- s_axis_tdata, input, 64
- s_axis_tkeep, input, 8
- s_axis_tvalid, input, 1
- s_axis_tready, output, 1
- s_axis_tlast, input, 1
- s_axis_tuser, input, 1, bad-frame flag valid on tlast
REQ-006 The block SHALL have the following AXI-Lite slave ports, with AXIL_ADDR_WIDTH address and 32-bit data:
- s_axil_aw* (awaddr, awprot, awvalid, awready)
- s_axil_w* (wdata, wstrb, wvalid, wready)
- s_axil_b* (bresp, bvalid, bready)
- s_axil_ar* (araddr, arprot, arvalid, arready)
- s_axil_r* (rdata, rresp, rvalid, rready)

Function
REQ-007 s_axis_tready SHALL be 1 in every cycle after reset release; a beat is accepted when tvalid&tready.
REQ-008 Beat byte count SHALL equal popcount(tkeep) (0..8); a frame length accumulator (16-bit) SHALL add it per beat and SHALL restart from that beat's count on the first beat after tlast.
REQ-009 On an accepted beat with tlast, in the following cycle:
- if tuser=0, FRAMES_GOOD SHALL increment; if tuser=1, FRAMES_BAD SHALL increment;
- if the final frame length < MIN_FRAME_LENGTH, RUNTS SHALL increment, regardless of tuser;
- LAST_LEN SHALL load the final frame length.
REQ-010 BYTES (64-bit) SHALL add the beat byte count for every accepted beat of good frames only; bytes of the current frame SHALL be committed at tlast when tuser=0 and discarded when tuser=1.
REQ-011 The register map (32-bit, word aligned, addr[4:2] decoded, upper bits ignored) SHALL be:
- 0x00 FRAMES_GOOD
- 0x04 FRAMES_BAD
- 0x08 BYTES[31:0]
- 0x0C BYTES[63:32] snapshot
- 0x10 RUNTS
- 0x14 LAST_LEN (zero-extended)
- 0x18 CTRL, write-only, reads return 0
REQ-012 A read of 0x08 SHALL latch BYTES[63:32] into a snapshot register in the same cycle; a read of 0x0C SHALL return the snapshot, so that a 0x08 then 0x0C read pair is coherent.
REQ-013 Read path SHALL use states IDLE -> RESP:
- arready=1 in IDLE;
- on arvalid, rdata SHALL be registered and rvalid SHALL be asserted the next cycle;
- the state SHALL return to IDLE on rready;
- read latency SHALL be 1 cycle; rresp SHALL be 2'b00.
REQ-014 Write path SHALL use states IDLE -> RESP:
- awready and wready SHALL both be asserted only when awvalid and wvalid are both high;
- bvalid SHALL be asserted next cycle until bready;
- bresp SHALL be 2'b00; writes to addresses other than 0x18 SHALL be ignored.
REQ-015 Writing CTRL with bit0=1 and wstrb[0]=1 SHALL clear all counters, LAST_LEN, the snapshot and the frame accumulator in the cycle after acceptance.
REQ-016 If a clear coincides with a counter update, the clear SHALL win; the frame in progress SHALL continue counting from zero.
REQ-017 Simultaneous read and write acceptance SHALL be allowed; the read SHALL return pre-clear values.

Reset
REQ-018 While rst_n=0, all counters, LAST_LEN, snapshot and accumulator SHALL be 0; s_axis_tready, arready, awready, wready, rvalid and bvalid SHALL be 0; rdata SHALL be 0; both FSMs SHALL be in IDLE.
REQ-019 Reset assertion mid-frame or mid-transaction SHALL abort it with no commit; the first beat after release SHALL start a new frame.

Configuration
REQ-020 With RX_AXIS_STATS_SATURATE_EN defined, every counter SHALL hold at all-ones instead of incrementing, and BYTES SHALL clamp at 2^64-1.
REQ-021 Without RX_AXIS_STATS_SATURATE_EN defined, all counters SHALL wrap modulo 2^width.

Verification
REQ-022 Scenario: a 64-byte good frame (8 beats, tkeep=FF, last tuser=0) -> FRAMES_GOOD=1, BYTES=64, RUNTS=0, LAST_LEN=64.
REQ-023 Scenario: a 60-byte frame with final tkeep=0F and tuser=1 -> FRAMES_BAD=1, RUNTS=1, BYTES unchanged, LAST_LEN=60.
REQ-024 Scenario: preload BYTES=0x1_FFFF_FFF8 via a stream of good frames, then a 9000-byte frame, then read 0x08 then 0x0C -> the coherent pair equals the total.
REQ-025 Scenario: write CTRL=1 on the same cycle as a good frame's tlast -> all registers read 0.
REQ-026 Scenario: with the macro defined, force FRAMES_GOOD=0xFFFFFFFF and send 1 good frame -> stays 0xFFFFFFFF; without the macro -> reads 0.
REQ-027 Scenario: drop rst_n mid-frame after 3 beats, release, send a 64-byte frame -> LAST_LEN=64 and FRAMES_GOOD=1.
